// File: rtl/up_down_mod_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with parallel load, wrap or saturate at the
// limits, a one-cycle limit pulse (wrap) and a sticky limit flag (ovf).
module up_down_mod_counter #(
    parameter int          WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 9,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV = MAX_VAL[WIDTH-1:0];

    logic             at_lim;
    logic             limit;
    logic [WIDTH-1:0] q_nxt;

    assign at_lim = up ? (q == MAXV) : (q == '0);
    // tc looks only at count state and enable; load does not mask it
    assign tc     = en & at_lim;
    assign limit  = en & ~load & at_lim;

    always_comb begin
        q_nxt = q;
        if (load) begin
            q_nxt = (load_val > MAXV) ? MAXV : load_val;
        end else if (en) begin
            if (at_lim) begin
                if (!SATURATE) q_nxt = up ? '0 : MAXV;
            end else begin
                // at_lim excludes the limits, so +/-1 stays inside 0..MAX_VAL
                q_nxt = up ? q + 1'b1 : q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= limit;
            // a limit event on the same edge as clear_ovf keeps the flag set
            ovf  <= limit | (ovf & ~clear_ovf);
        end
    end

endmodule
